// File: rtl/axi_ar_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_ar_rr_arbiter
//
// Round-robin arbiter that shares one AXI read-address (AR) master channel
// between NumInp requesters. Once the selected request is presented on
// mst_valid_o and not immediately accepted, the grant is locked until the
// master handshake completes (AXI valid stability). Each requester has an
// outstanding-read counter; a requester with MaxTrans reads in flight is not
// eligible for a new grant until a completion (done_valid_i) frees a slot.
//
// Parameters
//   NumInp    number of requesters (>= 2)
//   MaxTrans  maximum outstanding reads per requester (>= 1)
//   ar_chan_t AR payload type
//   IdxWidth  requester index width (derived)
//   CntWidth  outstanding counter width (derived)
//
// Ports
//   clk_i         clock, all state on the rising edge
//   rst_ni        synchronous reset, active low
//   slv_ar_i      per-requester AR payload
//   slv_valid_i   per-requester AR valid
//   slv_ready_o   per-requester AR ready (one-hot or zero)
//   mst_ar_o      payload of the granted requester
//   mst_valid_o   master AR valid
//   mst_ready_i   master AR ready
//   mst_idx_o     granted requester index (0 when mst_valid_o=0)
//   done_valid_i  one read of requester done_idx_i has completed
//   done_idx_i    owner of the completed read (values >= NumInp are ignored)
//   busy_o        requester has at least one read outstanding
//   stall_cnt_o   (only with AXI_AR_ARB_STALL_CNT_EN) per-requester count of
//                 cycles spent valid but not ready, saturating at 16'hFFFF
//
// Optional feature macro: AXI_AR_ARB_STALL_CNT_EN
// -----------------------------------------------------------------------------
module axi_ar_rr_arbiter #(
   parameter int unsigned   NumInp   = 4,
   parameter int unsigned   MaxTrans = 8,
   parameter type           ar_chan_t = logic,
   localparam int unsigned  IdxWidth = $clog2(NumInp),
   localparam int unsigned  CntWidth = $clog2(MaxTrans + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  ar_chan_t [NumInp-1:0]         slv_ar_i,
   input  logic     [NumInp-1:0]         slv_valid_i,
   output logic     [NumInp-1:0]         slv_ready_o,
   output ar_chan_t                      mst_ar_o,
   output logic                          mst_valid_o,
   input  logic                          mst_ready_i,
   output logic     [IdxWidth-1:0]       mst_idx_o,
   input  logic                          done_valid_i,
   input  logic     [IdxWidth-1:0]       done_idx_i,
`ifdef AXI_AR_ARB_STALL_CNT_EN
   output logic     [NumInp-1:0][15:0]   stall_cnt_o,
`endif
   output logic     [NumInp-1:0]         busy_o
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);

   state_e                           state_q, state_d;
   logic   [IdxWidth-1:0]            sel_q, sel_d;
   logic   [IdxWidth-1:0]            rr_ptr_q;
   logic   [NumInp-1:0][CntWidth-1:0] cnt_q;

   logic   [NumInp-1:0]              eligible;
   logic                             pick_found;
   logic   [IdxWidth-1:0]            pick_idx;
   logic   [IdxWidth-1:0]            cand_idx;
   logic                             hs;
   logic   [NumInp-1:0]              inc;
   logic   [NumInp-1:0]              dec;

   // (base + off) mod NumInp for base < NumInp and off <= NumInp.
   function automatic logic [IdxWidth-1:0] wrap_idx(input int unsigned base,
                                                     input int unsigned off);
      int unsigned s;
      s = base + off;
      if (s >= NumInp) begin
         s = s - NumInp;
      end
      return IdxWidth'(s);
   endfunction

   // Eligibility uses only registered counters, so done_valid_i never
   // reaches mst_valid_o combinationally.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         eligible[i] = slv_valid_i[i] && (cnt_q[i] < CntMax);
      end
   end

   // First eligible requester at or after rr_ptr_q, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int unsigned off = 0; off < NumInp; off++) begin
         cand_idx = wrap_idx(32'(rr_ptr_q), off);
         if (!pick_found && eligible[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      mst_valid_o = 1'b0;
      mst_idx_o   = '0;
      hs          = 1'b0;
      slv_ready_o = '0;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               mst_valid_o = 1'b1;
               mst_idx_o   = pick_idx;
               if (mst_ready_i) begin
                  hs = 1'b1;
               end else begin
                  state_d = LOCKED;
                  sel_d   = pick_idx;
               end
            end
         end
         LOCKED: begin
            // Grant is held regardless of other valids or the counter.
            mst_valid_o = 1'b1;
            mst_idx_o   = sel_q;
            if (mst_ready_i) begin
               hs      = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (hs) begin
         slv_ready_o[mst_idx_o] = 1'b1;
      end
   end

   assign mst_ar_o = slv_ar_i[mst_idx_o];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         if (hs) begin
            rr_ptr_q <= wrap_idx(32'(mst_idx_o), 1);
         end
      end
   end

   // Outstanding-read counters: handshake increments, completion decrements.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         inc[i] = slv_ready_o[i];
         dec[i] = done_valid_i && (done_idx_i == IdxWidth'(i));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NumInp; i++) begin
            if (inc[i] && !dec[i]) begin
               if (cnt_q[i] != CntMax) begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else if (dec[i] && !inc[i]) begin
               if (cnt_q[i] != '0) begin
                  cnt_q[i] <= cnt_q[i] - 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      busy_o = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         busy_o[i] = (cnt_q[i] != '0);
      end
   end

`ifdef AXI_AR_ARB_STALL_CNT_EN
   logic [NumInp-1:0][15:0] stall_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NumInp; i++) begin
            if (slv_valid_i[i] && !slv_ready_o[i] && (stall_q[i] != '1)) begin
               stall_q[i] <= stall_q[i] + 16'd1;
            end
         end
      end
   end

   assign stall_cnt_o = stall_q;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (state_q == LOCKED) begin
            a_valid_held: assert (slv_valid_i[sel_q]);
         end
         for (int unsigned i = 0; i < NumInp; i++) begin
            if (dec[i] && !inc[i]) begin
               a_no_underflow: assert (cnt_q[i] != '0);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_ar_rr_arbiter
//
// Directed, table-driven bench for axi_ar_rr_arbiter with NumInp=4,
// MaxTrans=2 and an 8-bit payload (requester i drives 8'hA0+i). Each vector
// drives the inputs for one cycle and states the expected combinational
// outputs plus busy_o as seen before that cycle's clock edge.
// -----------------------------------------------------------------------------
module tb_axi_ar_rr_arbiter;

   localparam int unsigned NI = 4;
   localparam int unsigned MT = 2;
   localparam int unsigned IW = 2;

   typedef logic [7:0] ar_t;

   typedef struct packed {
      logic [3:0] valid;
      logic       ready;
      logic       done_v;
      logic [1:0] done_idx;
      logic       exp_v;
      logic [1:0] exp_idx;
      logic [3:0] exp_rdy;
      logic [3:0] exp_busy;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst_ni;
   ar_t  [NI-1:0]       slv_ar;
   logic [NI-1:0]       slv_valid;
   logic [NI-1:0]       slv_ready;
   ar_t                 mst_ar;
   logic                mst_valid;
   logic                mst_ready;
   logic [IW-1:0]       mst_idx;
   logic                done_valid;
   logic [IW-1:0]       done_idx;
   logic [NI-1:0]       busy;
`ifdef AXI_AR_ARB_STALL_CNT_EN
   logic [NI-1:0][15:0] stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl [26];

   always #5 clk = ~clk;

   axi_ar_rr_arbiter #(
      .NumInp   (NI),
      .MaxTrans (MT),
      .ar_chan_t(ar_t)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .slv_ar_i    (slv_ar),
      .slv_valid_i (slv_valid),
      .slv_ready_o (slv_ready),
      .mst_ar_o    (mst_ar),
      .mst_valid_o (mst_valid),
      .mst_ready_i (mst_ready),
      .mst_idx_o   (mst_idx),
      .done_valid_i(done_valid),
      .done_idx_i  (done_idx),
`ifdef AXI_AR_ARB_STALL_CNT_EN
      .stall_cnt_o (stall_cnt),
`endif
      .busy_o      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_ni     = 1'b0;
      slv_valid  = '0;
      mst_ready  = 1'b0;
      done_valid = 1'b0;
      done_idx   = '0;
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
   endtask

   // Called at posedge+1; drives one vector, checks mid-cycle, returns at the
   // next posedge+1.
   task automatic apply(input int k);
      vec_t v;
      ar_t  exp_ar;
      v          = tbl[k];
      slv_valid  = v.valid;
      mst_ready  = v.ready;
      done_valid = v.done_v;
      done_idx   = v.done_idx;
      #4;
      check($sformatf("v%0d mst_valid", k), 32'(mst_valid), 32'(v.exp_v));
      check($sformatf("v%0d mst_idx", k), 32'(mst_idx), 32'(v.exp_idx));
      check($sformatf("v%0d slv_ready", k), 32'(slv_ready), 32'(v.exp_rdy));
      check($sformatf("v%0d busy", k), 32'(busy), 32'(v.exp_busy));
      if (v.exp_v) begin
         exp_ar = 8'hA0 | {6'd0, v.exp_idx};
         check($sformatf("v%0d mst_ar", k), 32'(mst_ar), 32'(exp_ar));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int first, input int last);
      for (int k = first; k < last; k++) begin
         apply(k);
      end
   endtask

   initial begin
      // valid  rdy  dv   didx  ev    eidx  erdy     ebusy
      // Round robin with everyone valid and the master always ready.
      tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0001, 4'b0000};
      tbl[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 4'b0001};
      tbl[2]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 4'b0011};
      tbl[3]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'b1000, 4'b0111};
      tbl[4]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0001, 4'b1111};
      tbl[5]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 4'b1111};
      // Lock on requester 1 for three stalled cycles, then requester 3.
      tbl[6]  = '{4'b1010, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b0000};
      tbl[7]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b0000};
      tbl[8]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b0000};
      tbl[9]  = '{4'b1010, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0010, 4'b0000};
      tbl[10] = '{4'b1010, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'b1000, 4'b0010};
      // Requester 2 fills MaxTrans, is blocked, then freed by a completion.
      tbl[11] = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 4'b0000};
      tbl[12] = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 4'b0100};
      tbl[13] = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0100};
      tbl[14] = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 4'b0100};
      tbl[15] = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 4'b0100};
      tbl[16] = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0100};
      // Simultaneous handshake and completion on requester 0.
      tbl[17] = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0001, 4'b0000};
      tbl[18] = '{4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 4'b0001, 4'b0001};
      tbl[19] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0001};
      tbl[20] = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0001};
      tbl[21] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000};
      // Move rr_ptr to 3, lock requester 0, then reset mid-lock.
      tbl[22] = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 4'b0000};
      tbl[23] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000, 4'b0100};
      tbl[24] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000};
      tbl[25] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0001, 4'b0000};

      for (int i = 0; i < int'(NI); i++) begin
         slv_ar[i] = 8'hA0 | 8'(i);
      end

      do_reset();
      #4;
      check("reset mst_valid", 32'(mst_valid), 32'd0);
      check("reset slv_ready", 32'(slv_ready), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset mst_idx", 32'(mst_idx), 32'd0);
      @(posedge clk);
      #1;

      run(0, 6);
      do_reset();
      run(6, 11);
      do_reset();
      run(11, 17);
      do_reset();
      run(17, 22);
      do_reset();
      run(22, 24);

      // Reset while requester 0 is locked and unaccepted.
      rst_ni    = 1'b0;
      slv_valid = '0;
      mst_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      run(24, 26);

`ifdef AXI_AR_ARB_STALL_CNT_EN
      // Requester 3 waits behind requester 0: four stalled lock cycles plus
      // the cycle requester 0 is accepted.
      do_reset();
      slv_valid = 4'b1001;
      mst_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      mst_ready = 1'b1;
      #4;
      check("stall hs idx", 32'(mst_idx), 32'd0);
      @(posedge clk);
      #1;
      check("stall_cnt[3] held off", 32'(stall_cnt[3]), 32'd5);
      check("stall_cnt[0] locked", 32'(stall_cnt[0]), 32'd4);
      #4;
      check("stall grant 3", 32'(mst_idx), 32'd3);
      @(posedge clk);
      #1;
      check("stall_cnt[3] after grant", 32'(stall_cnt[3]), 32'd5);
      check("stall_cnt[0] after grant", 32'(stall_cnt[0]), 32'd5);
      slv_valid = '0;
      mst_ready = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
